// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave: FSM state encoding, frame command codes
// and the fixed command width.
package spi_pkg;

    localparam int CMD_W = 2;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WRITE,
        READ_ADD,
        READ_DATA,
        TX_WAIT,
        TX,
        DRAIN
    } spi_state_t;

    localparam logic [CMD_W-1:0] WR_ADDR = 2'b00;
    localparam logic [CMD_W-1:0] WR_DATA = 2'b01;
    localparam logic [CMD_W-1:0] RD_ADDR = 2'b10;
    localparam logic [CMD_W-1:0] RD_DATA = 2'b11;

endpackage

// File: rtl/spi_tx_serializer.sv
// Parallel-load, MSB-first shift-out of the read payload onto a registered MISO.
// done is high while the final bit is on the line.
module spi_tx_serializer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] data,
    output logic         bit_out,
    output logic         done
);

    localparam int CW = $clog2(W);

    logic [W-1:0]  shift_reg;
    logic [CW-1:0] cnt_reg;
    logic          out_reg;

    // cnt_reg holds the number of bits still to follow the one on the line;
    // the line returns to 0 whenever the serializer is neither loaded nor shifted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_reg <= '0;
            cnt_reg   <= '0;
            out_reg   <= 1'b0;
        end else if (load) begin
            out_reg   <= data[W-1];
            shift_reg <= {data[W-2:0], 1'b0};
            cnt_reg   <= CW'(W - 1);
        end else if (shift) begin
            if (cnt_reg == '0) begin
                out_reg <= 1'b0;
            end else begin
                out_reg   <= shift_reg[W-1];
                shift_reg <= {shift_reg[W-2:0], 1'b0};
                cnt_reg   <= cnt_reg - CW'(1);
            end
        end else begin
            out_reg <= 1'b0;
        end
    end

    assign bit_out = out_reg;
    assign done    = (cnt_reg == '0);

endmodule

// File: rtl/spi_slave_param.sv
// SPI slave with {cmd, payload} frames clocked directly by clk; supports
// write address/data and a two-frame read (address, then data returned on MISO).
module spi_slave_param
    import spi_pkg::*;
#(
    parameter int PAYLOAD_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   SS_n,
    input  logic                   MOSI,
    input  logic [PAYLOAD_W-1:0]   tx_data,
    input  logic                   tx_valid,
    output logic                   MISO,
    output logic [PAYLOAD_W+1:0]   rx_data,
    output logic                   rx_valid,
    output logic                   err
);

    localparam int FRAME_W = PAYLOAD_W + CMD_W;
    localparam int CNT_W   = $clog2(PAYLOAD_W + 3);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);

    spi_state_t state_reg, state_next;

    logic [CNT_W-1:0]   bit_cnt_reg, bit_cnt_next;
    logic [FRAME_W-1:0] shift_reg, shift_next;
    logic [FRAME_W-1:0] rx_data_reg, rx_data_next;
    logic               rx_valid_reg, rx_valid_next;
    logic               err_reg, err_next;
    logic               rd_pending_reg, rd_pending_next;

    logic               ser_load;
    logic               ser_shift;
    logic               ser_done;
    logic               frame_done;
    logic [FRAME_W-1:0] shift_in;

    assign frame_done = (bit_cnt_reg == LAST_BIT);
    assign shift_in   = {shift_reg[FRAME_W-2:0], MOSI};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        bit_cnt_next    = bit_cnt_reg;
        shift_next      = shift_reg;
        rx_data_next    = rx_data_reg;
        rx_valid_next   = 1'b0;
        err_next        = 1'b0;
        rd_pending_next = rd_pending_reg;
        ser_load        = 1'b0;
        ser_shift       = 1'b0;

        // Deselect wins over everything: any partial frame is silently dropped.
        if (SS_n) begin
            state_next   = IDLE;
            bit_cnt_next = '0;
            shift_next   = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_next   = CMD;
                    bit_cnt_next = '0;
                end
                CMD: begin
                    shift_next   = {{(FRAME_W-1){1'b0}}, MOSI};
                    bit_cnt_next = CNT_W'(1);
                    if (!MOSI) begin
                        state_next = WRITE;
                    end else if (rd_pending_reg) begin
                        state_next = READ_DATA;
                    end else begin
                        state_next = READ_ADD;
                    end
                end
                WRITE: begin
                    shift_next   = shift_in;
                    bit_cnt_next = bit_cnt_reg + CNT_W'(1);
                    if (frame_done) begin
                        rx_data_next  = shift_in;
                        rx_valid_next = 1'b1;
                        state_next    = DRAIN;
                    end
                end
                READ_ADD: begin
                    if (bit_cnt_reg == CNT_W'(1) && MOSI != RD_ADDR[0]) begin
                        err_next   = 1'b1;
                        state_next = DRAIN;
                    end else begin
                        shift_next   = shift_in;
                        bit_cnt_next = bit_cnt_reg + CNT_W'(1);
                        if (frame_done) begin
                            rx_data_next    = shift_in;
                            rx_valid_next   = 1'b1;
                            rd_pending_next = 1'b1;
                            state_next      = DRAIN;
                        end
                    end
                end
                READ_DATA: begin
                    if (bit_cnt_reg == CNT_W'(1) && MOSI != RD_DATA[0]) begin
                        err_next   = 1'b1;
                        state_next = DRAIN;
                    end else begin
                        shift_next   = shift_in;
                        bit_cnt_next = bit_cnt_reg + CNT_W'(1);
                        if (frame_done) begin
                            rx_data_next    = shift_in;
                            rx_valid_next   = 1'b1;
                            rd_pending_next = 1'b0;
                            state_next      = TX_WAIT;
                        end
                    end
                end
                TX_WAIT: begin
                    if (tx_valid) begin
                        ser_load   = 1'b1;
                        state_next = TX;
                    end
                end
                TX: begin
                    ser_shift = 1'b1;
                    if (ser_done) begin
                        state_next = DRAIN;
                    end
                end
                DRAIN: begin
                    state_next = DRAIN;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            rx_data_reg    <= '0;
            rx_valid_reg   <= 1'b0;
            err_reg        <= 1'b0;
            rd_pending_reg <= 1'b0;
        end else begin
            bit_cnt_reg    <= bit_cnt_next;
            shift_reg      <= shift_next;
            rx_data_reg    <= rx_data_next;
            rx_valid_reg   <= rx_valid_next;
            err_reg        <= err_next;
            rd_pending_reg <= rd_pending_next;
        end
    end

    spi_tx_serializer #(
        .W(PAYLOAD_W)
    ) u_tx_serializer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (ser_load),
        .shift  (ser_shift),
        .data   (tx_data),
        .bit_out(MISO),
        .done   (ser_done)
    );

    assign rx_data  = rx_data_reg;
    assign rx_valid = rx_valid_reg;
    assign err      = err_reg;

endmodule

// File: doc/spi_slave_param.md
SPI_SLAVE_PARAM -- requirements
Module: spi_slave_param

Interface
REQ-001 Parameter PAYLOAD_W, default 8: address/data payload bits per frame (legal 4..16).
REQ-002 Parameter CMD_W is fixed at 2 and is not overridable: command bits per frame.
REQ-003 clk  input  1  system clock; SCLK is this clock, all sampling on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 SS_n  input  1  slave select, active-low, frames a transaction.
REQ-006 MOSI  input  1  serial data in, MSB first.
REQ-007 tx_data  input  PAYLOAD_W  read data from memory.
REQ-008 tx_valid  input  1  tx_data valid, single-cycle pulse.
REQ-009 MISO  output  1  serial data out, MSB first.
REQ-010 rx_data  output  PAYLOAD_W+2  {cmd[1:0], payload}.
REQ-011 rx_valid  output  1  one-cycle pulse, rx_data valid.
REQ-012 err  output  1  one-cycle pulse, protocol violation.

Function
REQ-013 States SHALL be IDLE, CMD, WRITE, READ_ADD, READ_DATA, TX_WAIT, TX, DRAIN.
REQ-014 SS_n high in any state SHALL force IDLE next cycle; partial frame discarded, no rx_valid, no err.
REQ-015 IDLE: SS_n low -> CMD; nothing sampled this cycle.
REQ-016 CMD: sample cmd[1]; 0 -> WRITE; 1 and rd_pending=0 -> READ_ADD; 1 and rd_pending=1 -> READ_DATA.
REQ-017 WRITE/READ_ADD/READ_DATA SHALL shift MOSI into a PAYLOAD_W+2 bit register each cycle, counting from the CMD bit.
REQ-018 After PAYLOAD_W+2 bits, rx_data SHALL load the register and rx_valid SHALL pulse the next cycle.
REQ-019 WRITE accepts cmd 00 (write address) and 01 (write data); after rx_valid -> DRAIN.
REQ-020 READ_ADD requires cmd 10: on completion rd_pending SHALL be set -> DRAIN.
REQ-021 READ_DATA requires cmd 11: on completion rd_pending SHALL be cleared -> TX_WAIT.
REQ-022 cmd[0] mismatch in READ_ADD (got 1) or READ_DATA (got 0): err pulse the cycle after cmd[0] is sampled, frame dropped, rd_pending unchanged -> DRAIN.
REQ-023 TX_WAIT: on tx_valid latch tx_data -> TX; waits indefinitely while SS_n low.
REQ-024 TX: MISO SHALL drive latched bits MSB first, one per cycle, PAYLOAD_W cycles, then -> DRAIN.
REQ-025 The first MISO bit SHALL be registered and appear the cycle after tx_valid.
REQ-026 MISO SHALL be 0 in every state except TX.
REQ-027 tx_valid outside TX_WAIT SHALL be ignored.
REQ-028 DRAIN: ignore MOSI; remain until SS_n high.
REQ-029 The bit counter SHALL be ceil(log2(PAYLOAD_W+3)) wide and SHALL never wrap within a frame.
REQ-030 rx_data SHALL hold its last value between frames.

Reset
REQ-031 rst_n low at a clock edge: state IDLE, rd_pending 0, counter 0, shift register 0.
REQ-032 rst_n low at a clock edge: MISO 0, rx_valid 0, err 0, rx_data 0.
REQ-033 Reset mid-frame SHALL abort the frame with no rx_valid or err pulse.
REQ-034 Reset during TX SHALL drive MISO to 0 on the next cycle.

Structure
REQ-035 A shared package spi_pkg SHALL hold the state encoding, the command codes (WR_ADDR=00, WR_DATA=01, RD_ADDR=10, RD_DATA=11) and CMD_W.
REQ-036 One sub-module, spi_tx_serializer, SHALL provide the PAYLOAD_W load/shift-out with done flag; all other logic stays in the top.

Verification (PAYLOAD_W=8, SS_n falls at cycle 0)
REQ-037 Write address: MOSI 00 + 0x3C, bits at cycles 1..10 -> rx_data=10'h03C, rx_valid high cycle 11 only.
REQ-038 Read address then read data: 10+0x55, SS_n high; then 11+0x00, tx_valid with 0xA7 -> two rx_valid pulses (10'h255, 10'h300); MISO 1,0,1,0,0,1,1,1 over 8 cycles from the cycle after tx_valid; rd_pending ends 0.
REQ-039 Abort: SS_n rises after 5 bits of a write -> no rx_valid; the next full frame decodes correctly.
REQ-040 Protocol error: with rd_pending=0 send 11 + 0x00 -> err pulse cycle 3, no rx_valid, MISO stays 0, rd_pending stays 0.
REQ-041 Reset mid-TX: rst_n low during bit 4 of MISO -> MISO 0 next cycle, state IDLE, rd_pending 0.
REQ-042 Parameter sweep PAYLOAD_W=4 and 16: write frames give rx_valid at cycle PAYLOAD_W+3.
